// File: rtl/spi_axi_master_arb.sv
// Two-requester AXI4 single-beat arbiter: independent round-robin write (AW/W/B)
// and read (AR/R) FSMs, each with one outstanding transaction.
module spi_axi_master_arb #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 3
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  // requester 0
  input  logic                          s0_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s0_aw_addr,
  output logic                          s0_aw_ready,
  input  logic                          s0_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     s0_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s0_w_strb,
  output logic                          s0_w_ready,
  output logic                          s0_b_valid,
  output logic [1:0]                    s0_b_resp,
  input  logic                          s0_b_ready,
  input  logic                          s0_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s0_ar_addr,
  output logic                          s0_ar_ready,
  output logic                          s0_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]     s0_r_data,
  output logic [1:0]                    s0_r_resp,
  input  logic                          s0_r_ready,
  // requester 1
  input  logic                          s1_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s1_aw_addr,
  output logic                          s1_aw_ready,
  input  logic                          s1_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     s1_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s1_w_strb,
  output logic                          s1_w_ready,
  output logic                          s1_b_valid,
  output logic [1:0]                    s1_b_resp,
  input  logic                          s1_b_ready,
  input  logic                          s1_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s1_ar_addr,
  output logic                          s1_ar_ready,
  output logic                          s1_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]     s1_r_data,
  output logic [1:0]                    s1_r_resp,
  input  logic                          s1_r_ready,
  // shared master port
  output logic                          m_aw_valid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_aw_addr,
  output logic [AXI_ID_WIDTH-1:0]       m_aw_id,
  output logic [7:0]                    m_aw_len,
  output logic [2:0]                    m_aw_size,
  output logic [1:0]                    m_aw_burst,
  output logic                          m_aw_lock,
  output logic [3:0]                    m_aw_cache,
  output logic [2:0]                    m_aw_prot,
  output logic [3:0]                    m_aw_qos,
  input  logic                          m_aw_ready,
  output logic                          m_w_valid,
  output logic [AXI_DATA_WIDTH-1:0]     m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_w_strb,
  output logic                          m_w_last,
  input  logic                          m_w_ready,
  input  logic                          m_b_valid,
  input  logic [1:0]                    m_b_resp,
  output logic                          m_b_ready,
  output logic                          m_ar_valid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_ar_addr,
  output logic [AXI_ID_WIDTH-1:0]       m_ar_id,
  output logic [7:0]                    m_ar_len,
  output logic [2:0]                    m_ar_size,
  output logic [1:0]                    m_ar_burst,
  output logic                          m_ar_lock,
  output logic [3:0]                    m_ar_cache,
  output logic [2:0]                    m_ar_prot,
  output logic [3:0]                    m_ar_qos,
  input  logic                          m_ar_ready,
  input  logic                          m_r_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_r_data,
  input  logic [1:0]                    m_r_resp,
  output logic                          m_r_ready,
  output logic [1:0]                    wr_gnt,
  output logic [1:0]                    rd_gnt
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic      wr_idx_q, wr_idx_d, wr_last_q, wr_last_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      rd_idx_q, rd_idx_d, rd_last_q, rd_last_d;

  assign m_aw_len   = '0;
  assign m_aw_size  = 3'b010;
  assign m_aw_burst = '0;
  assign m_aw_lock  = 1'b0;
  assign m_aw_cache = '0;
  assign m_aw_prot  = '0;
  assign m_aw_qos   = '0;
  assign m_w_last   = 1'b1;
  assign m_ar_len   = '0;
  assign m_ar_size  = 3'b010;
  assign m_ar_burst = '0;
  assign m_ar_lock  = 1'b0;
  assign m_ar_cache = '0;
  assign m_ar_prot  = '0;
  assign m_ar_qos   = '0;

  // Payloads follow the latched grant; only the valids/readies are state-gated.
  assign m_aw_addr = wr_idx_q ? s1_aw_addr : s0_aw_addr;
  assign m_w_data  = wr_idx_q ? s1_w_data  : s0_w_data;
  assign m_w_strb  = wr_idx_q ? s1_w_strb  : s0_w_strb;
  assign m_ar_addr = rd_idx_q ? s1_ar_addr : s0_ar_addr;
  assign m_aw_id   = AXI_ID_WIDTH'(wr_idx_q);
  assign m_ar_id   = AXI_ID_WIDTH'(rd_idx_q);
  assign wr_gnt    = (wr_state_q == W_IDLE) ? 2'b00 : {wr_idx_q, ~wr_idx_q};
  assign rd_gnt    = (rd_state_q == R_IDLE) ? 2'b00 : {rd_idx_q, ~rd_idx_q};

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_last_d   = wr_last_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_aw_valid  = 1'b0;
    m_w_valid   = 1'b0;
    m_b_ready   = 1'b0;
    s0_aw_ready = 1'b0;
    s1_aw_ready = 1'b0;
    s0_w_ready  = 1'b0;
    s1_w_ready  = 1'b0;
    s0_b_valid  = 1'b0;
    s1_b_valid  = 1'b0;
    s0_b_resp   = '0;
    s1_b_resp   = '0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (s0_aw_valid || s1_aw_valid) begin
          wr_idx_d   = (s0_aw_valid && s1_aw_valid) ? ~wr_last_q : s1_aw_valid;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        m_aw_valid = (wr_idx_q ? s1_aw_valid : s0_aw_valid) & ~aw_done_q;
        m_w_valid  = (wr_idx_q ? s1_w_valid  : s0_w_valid)  & ~w_done_q;
        if (wr_idx_q) begin
          s1_aw_ready = m_aw_ready & ~aw_done_q;
          s1_w_ready  = m_w_ready  & ~w_done_q;
        end else begin
          s0_aw_ready = m_aw_ready & ~aw_done_q;
          s0_w_ready  = m_w_ready  & ~w_done_q;
        end
        aw_done_d = aw_done_q | (m_aw_valid & m_aw_ready);
        w_done_d  = w_done_q  | (m_w_valid  & m_w_ready);
        if (aw_done_d && w_done_d) wr_state_d = W_RESP;
      end
      W_RESP: begin
        m_b_ready = wr_idx_q ? s1_b_ready : s0_b_ready;
        if (wr_idx_q) begin
          s1_b_valid = m_b_valid;
          s1_b_resp  = m_b_resp;
        end else begin
          s0_b_valid = m_b_valid;
          s0_b_resp  = m_b_resp;
        end
        if (m_b_valid && m_b_ready) begin
          wr_last_d  = wr_idx_q;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_idx_d    = rd_idx_q;
    rd_last_d   = rd_last_q;
    m_ar_valid  = 1'b0;
    m_r_ready   = 1'b0;
    s0_ar_ready = 1'b0;
    s1_ar_ready = 1'b0;
    s0_r_valid  = 1'b0;
    s1_r_valid  = 1'b0;
    s0_r_data   = '0;
    s1_r_data   = '0;
    s0_r_resp   = '0;
    s1_r_resp   = '0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s0_ar_valid || s1_ar_valid) begin
          rd_idx_d   = (s0_ar_valid && s1_ar_valid) ? ~rd_last_q : s1_ar_valid;
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_ar_valid = rd_idx_q ? s1_ar_valid : s0_ar_valid;
        if (rd_idx_q) s1_ar_ready = m_ar_ready;
        else          s0_ar_ready = m_ar_ready;
        if (m_ar_valid && m_ar_ready) rd_state_d = R_RESP;
      end
      R_RESP: begin
        m_r_ready = rd_idx_q ? s1_r_ready : s0_r_ready;
        if (rd_idx_q) begin
          s1_r_valid = m_r_valid;
          s1_r_data  = m_r_data;
          s1_r_resp  = m_r_resp;
        end else begin
          s0_r_valid = m_r_valid;
          s0_r_data  = m_r_data;
          s0_r_resp  = m_r_resp;
        end
        if (m_r_valid && m_r_ready) begin
          rd_last_d  = rd_idx_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_state_q <= W_IDLE;
      wr_idx_q   <= 1'b0;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_last_q  <= wr_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state_q <= R_IDLE;
      rd_idx_q   <= 1'b0;
      rd_last_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: doc/spi_axi_master_arb.md
# spi_axi_master_arb

Two-requester arbiter that shares one AXI4 master port between the SPI-slave AXI plug and a second single-beat AXI requester, such as a debug or boot-loader master. Write (AW/W/B) and read (AR/R) directions are arbitrated independently, each round-robin, with one outstanding transaction per direction. The block sits between the requesters' AXI master ports and the SoC interconnect slave port. It supports only single-beat (len=0) transfers, which is the traffic the SPI plug issues.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 32, address width on all ports
- AXI_DATA_WIDTH, 64, data width on all ports (strobe width = AXI_DATA_WIDTH/8)
- AXI_ID_WIDTH, 3, ID width of m_aw_id/m_ar_id; must be >= 1

Ports. Prefix `sN_` is repeated for N = 0, 1 with identical widths. Directions are given for `sN_`; the `m_` twin has the opposite direction.
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- sN_aw_valid / m_aw_valid  in/out  1  write address valid
- sN_aw_addr / m_aw_addr  in/out  AXI_ADDR_WIDTH  write address
- sN_aw_ready / m_aw_ready  out/in  1  write address ready
- sN_w_valid / m_w_valid  in/out  1  write data valid
- sN_w_data / m_w_data  in/out  AXI_DATA_WIDTH  write data
- sN_w_strb / m_w_strb  in/out  AXI_DATA_WIDTH/8  write strobes
- sN_w_ready / m_w_ready  out/in  1  write data ready
- sN_b_valid / m_b_valid  out/in  1  write response valid
- sN_b_resp / m_b_resp  out/in  2  write response
- sN_b_ready / m_b_ready  in/out  1  write response ready
- sN_ar_valid / m_ar_valid  in/out  1  read address valid
- sN_ar_addr / m_ar_addr  in/out  AXI_ADDR_WIDTH  read address
- sN_ar_ready / m_ar_ready  out/in  1  read address ready
- sN_r_valid / m_r_valid  out/in  1  read data valid
- sN_r_data / m_r_data  out/in  AXI_DATA_WIDTH  read data
- sN_r_resp / m_r_resp  out/in  2  read response
- sN_r_ready / m_r_ready  in/out  1  read data ready
- m_aw_id, m_ar_id  out  AXI_ID_WIDTH  granted requester index, zero-extended
- wr_gnt, rd_gnt  out  2  one-hot current grant per direction (debug/status)

Fixed outputs: m_*_len=0, size=3'b010, burst=0, w_last=1, all remaining AW/AR attributes 0.

## Operation
Write FSM states:
- W_IDLE
  - Request for requester N is sN_aw_valid. A lone request is granted.
  - If both request, grant the requester that was not granted last (`wr_last` pointer). The reset value of wr_last is 1, so s0 wins the first tie.
  - Latch the grant and go to W_ADDR.
- W_ADDR
  - Forward the granted requester's AW and W channels combinationally to m_. Non-granted readies are 0.
  - Track aw_done and w_done flags. They are set on the respective m_ handshake and may complete in either order or the same cycle; after a channel's handshake its m_ valid is masked to 0.
  - When both flags are set (including the cycle the second completes), go to W_RESP.
- W_RESP
  - Route m_b_* to the granted sN_b_*; m_b_ready = granted sN_b_ready.
  - On B handshake: update wr_last to the granted index, clear the flags, go to W_IDLE.

Read FSM (R_IDLE / R_ADDR / R_RESP):
- Same structure, using sN_ar_valid, the AR handshake, then the R handshake, with its own `rd_last` pointer (reset 1).
- An R beat with r_last=0 is not expected; the FSM returns to R_IDLE on the first R handshake.

General rules:
- The read and write FSMs are fully independent. A requester may hold a write grant and a read grant at the same time.
- A non-granted requester sees all readies and all response valids at 0 for that direction.
- Response data, resp and valid are never routed to the non-granted requester.
- m_aw_id and m_ar_id equal the granted index. Returned B/R IDs are ignored; routing is by FSM state.

## Timing
- Reset values: both FSMs IDLE, wr_gnt=rd_gnt=2'b00, all m_ valids 0, all sN readies and response valids 0, both last pointers 1.
- Grant latency: request seen in IDLE at cycle t, m_aw_valid/m_ar_valid high at t+1.
- Back-to-back: after a B/R handshake at cycle t, the FSM is in IDLE at t+1 and the next grant is visible at t+2. This gives a minimum 1-cycle bubble per direction.
- The address/data path through the block is combinational; the FSM adds no extra pipeline stage.
- A requester dropping aw_valid/ar_valid before its handshake is a protocol violation and is not handled. The grant persists until the response completes.
- A reset asserted mid-transaction returns every output to its reset value asynchronously. Outstanding responses are discarded.

## Test plan
- Reset: hold axi_aresetn=0 with all valids high -> all m_ valids 0, wr_gnt=rd_gnt=0; release -> m_aw_valid high 1 cycle later with m_aw_id=0.
- Tie: s0 and s1 both issue writes (0x1000 / 0x2000) continuously -> m_aw_addr sequence 0x1000, 0x2000, 0x1000, with wr_gnt alternating 01, 10, 01 and one idle cycle between grants.
- Decoupled AW/W: m_w_ready arrives 3 cycles after m_aw_ready -> m_aw_valid drops after its handshake, W still presented, W_RESP entered only after the W handshake; B (resp=2'b10) is returned only to the granted requester.
- Concurrency: s0 reads 0x40 while s1 writes 0x80 -> both m_ar_valid and m_aw_valid high in the same cycle; r_data 0xDEADBEEF reaches s0 only, B reaches s1 only.
- Backpressure: granted requester holds b_ready=0 for 5 cycles -> m_b_ready=0 for those cycles, FSM stays in W_RESP, other requester sees aw_ready=0.
- Mid-operation reset: assert reset in R_RESP with m_r_valid high -> s0_r_valid drops in the same cycle; after release, a fresh read completes normally.
